// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low key matrix scanner with debounce.
// Drives one row low at a time, latches the first key seen and debounces
// its press and release. Emits a 4-bit key code and a level pressed flag.
// Optional feature macro: KEYPAD_REPEAT_EN adds single-clock auto-repeat
// drops of is_pressed while a key is held.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] button,
  output logic       is_pressed
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_FULL  = DW'(DEBOUNCE_CYCLES);

  if (SCAN_DIV < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_param
    $error("keypad_scanner: timing parameters must be >= 2");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    col_m_q, col_s_q;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]    button_q, button_d;
  logic          is_pressed_q, is_pressed_d;
  logic          sel_high;
  logic          release_ok;
  logic [1:0]    first_low;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] REP_DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_RATE_LAST = RW'(REPEAT_RATE - 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_first_q, rep_first_d;
  logic          rep_hit;
`endif

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;
      4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;
      4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;
      4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hF;
      4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hE;
      default: key_code = 4'hD;
    endcase
  endfunction

  assign row_n      = ~(4'b0001 << row_q);
  assign button     = button_q;
  assign is_pressed = is_pressed_q;
  assign sel_high   = col_s_q[col_q];
  // Release needs DEBOUNCE_CYCLES more high samples after the first one,
  // mirroring press, which needs that many low samples after detection.
  assign release_ok = sel_high && (deb_cnt_q >= DEB_FULL);

  // Lowest low column index wins when several columns are low.
  always_comb begin
    first_low = 2'd3;
    if (!col_s_q[0])      first_low = 2'd0;
    else if (!col_s_q[1]) first_low = 2'd1;
    else if (!col_s_q[2]) first_low = 2'd2;
  end

`ifdef KEYPAD_REPEAT_EN
  // Auto-repeat fires first after REPEAT_DELAY clocks, then every REPEAT_RATE.
  always_comb begin
    rep_hit = rep_first_q ? (rep_cnt_q == REP_DLY_LAST) : (rep_cnt_q == REP_RATE_LAST);
  end
`endif

  // Next-state and output logic for the scan/debounce/held sequence.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    scan_cnt_d   = scan_cnt_q;
    deb_cnt_d    = deb_cnt_q;
    button_d     = button_q;
    is_pressed_d = is_pressed_q;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d    = rep_cnt_q;
    rep_first_d  = rep_first_q;
`endif
    case (state_q)
      SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (col_s_q != 4'hF) begin
            col_d     = first_low;
            deb_cnt_d = '0;
            state_d   = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (sel_high) begin
          state_d    = SCAN;
          row_d      = row_q + 2'd1;
          scan_cnt_d = '0;
          deb_cnt_d  = '0;
        end else if (deb_cnt_q >= DEB_LAST) begin
          button_d     = key_code(row_q, col_q);
          is_pressed_d = 1'b1;
          deb_cnt_d    = '0;
          state_d      = HELD;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt_d    = '0;
          rep_first_d  = 1'b1;
`endif
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sel_high) begin
          deb_cnt_d = '0;
        end else if (release_ok) begin
          is_pressed_d = 1'b0;
          state_d      = SCAN;
          row_d        = row_q + 2'd1;
          scan_cnt_d   = '0;
          deb_cnt_d    = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
`ifdef KEYPAD_REPEAT_EN
        if (!release_ok) begin
          if (rep_hit) begin
            is_pressed_d = 1'b0;
            rep_cnt_d    = '0;
            rep_first_d  = 1'b0;
          end else begin
            is_pressed_d = 1'b1;
            if (rep_cnt_q != '1) rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = SCAN;
    endcase
  end

  // State, counters, outputs and the two-flop column synchroniser.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= SCAN;
      col_m_q      <= 4'hF;
      col_s_q      <= 4'hF;
      row_q        <= 2'd0;
      col_q        <= 2'd0;
      scan_cnt_q   <= '0;
      deb_cnt_q    <= '0;
      button_q     <= 4'h0;
      is_pressed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_m_q      <= col_n;
      col_s_q      <= col_m_q;
      row_q        <= row_d;
      col_q        <= col_d;
      scan_cnt_q   <= scan_cnt_d;
      deb_cnt_q    <= deb_cnt_d;
      button_q     <= button_d;
      is_pressed_q <= is_pressed_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Auto-repeat counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a key matrix model.
module tb_keypad_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  button;
  logic        is_pressed;
  logic [15:0] keys = 16'h0;  // bit r*4+c = key at row r, column c held

  int   n_chk = 0;
  int   n_err = 0;
  int   rises = 0;
  logic prev_p = 1'b0;

  keypad_scanner #(
    .SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(40), .REPEAT_RATE(16)
  ) dut (
    .clock(clock), .reset(reset), .col_n(col_n),
    .row_n(row_n), .button(button), .is_pressed(is_pressed)
  );

  always #5 clock = ~clock;

  // Passive matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (is_pressed && !prev_p) rises++;
      prev_p = is_pressed;
    end
  endtask

  task automatic wait_pressed(input logic lvl, input int budget, input string tag);
    int k = 0;
    while (is_pressed !== lvl && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, is_pressed, lvl);
  endtask

  task automatic wait_row(input logic [3:0] rn, input string tag);
    int k = 0;
    while (row_n !== rn && k < 64) begin
      tick(1);
      k++;
    end
    check(tag, row_n, rn);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    @(negedge clock);
    reset  = 1'b0;
    prev_p = is_pressed;
  endtask

  logic [3:0] exp_row;
  logic       exp_p;

  initial begin
    // 1: clean press/release of r1c2, exact latency
    keys[1*4+2] = 1'b1;
    #2;
    check("rst_row", row_n, 4'b1110);
    check("rst_btn", button, 4'h0);
    check("rst_prs", is_pressed, 1'b0);
    do_reset();
    tick(15);
    check("t1_pre_prs", is_pressed, 1'b0);
    check("t1_pre_btn", button, 4'h0);
    check("t1_frozen_row", row_n, 4'b1101);
    tick(1);
    check("t1_prs", is_pressed, 1'b1);
    check("t1_btn", button, 4'h6);
    tick(4);
    keys = 16'h0;
    tick(10);
    check("t1_rel_early", is_pressed, 1'b1);
    tick(1);
    check("t1_rel", is_pressed, 1'b0);
    check("t1_btn_hold", button, 4'h6);
    check("t1_next_row", row_n, 4'b1011);

    // 2: r3c2 bounce while row 3 is driven, then stable hold
    rises = 0;
    wait_row(4'b0111, "t2_row3");
    keys[3*4+2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) keys[3*4+2] = 1'b0;
      if (i == 5) keys[3*4+2] = 1'b1;
      tick(1);
      check("t2_bounce_prs", is_pressed, 1'b0);
      check("t2_bounce_btn", button, 4'h6);
    end
    wait_pressed(1'b1, 200, "t2_prs");
    check("t2_btn", button, 4'hE);
    keys = 16'h0;
    wait_pressed(1'b0, 100, "t2_rel");
    check("t2_one_rise", rises, 1);

    // 3: r0c1 and r0c3 together; lowest column wins, other accepted later
    rises = 0;
    keys[0*4+1] = 1'b1;
    keys[0*4+3] = 1'b1;
    wait_pressed(1'b1, 200, "t3_prs");
    check("t3_btn", button, 4'h2);
    keys[0*4+1] = 1'b0;
    wait_pressed(1'b0, 100, "t3_rel_c1");
    check("t3_btn_hold", button, 4'h2);
    wait_pressed(1'b1, 200, "t3_prs_c3");
    check("t3_btn_c3", button, 4'hA);
    check("t3_rises", rises, 2);
    keys = 16'h0;
    wait_pressed(1'b0, 100, "t3_rel_c3");

    // 4: reset asserted mid-debounce of r2c0
    keys[2*4+0] = 1'b1;
    wait_row(4'b1011, "t4_row2");
    tick(6);
    check("t4_deb_prs", is_pressed, 1'b0);
    check("t4_deb_row", row_n, 4'b1011);
    #2 reset = 1'b1;
    #1;
    check("t4_rst_row", row_n, 4'b1110);
    check("t4_rst_prs", is_pressed, 1'b0);
    check("t4_rst_btn", button, 4'h0);
    @(negedge clock);
    reset  = 1'b0;
    prev_p = is_pressed;
    wait_pressed(1'b1, 200, "t4_prs");
    check("t4_btn", button, 4'h7);
    keys = 16'h0;
    wait_pressed(1'b0, 100, "t4_rel");

    // 5: idle scan rotation, 4 clocks per row
    do_reset();
    for (int k = 0; k < 64; k++) begin
      exp_row = 4'b1111;
      exp_row[(k/4)%4] = 1'b0;
      check("t5_row", row_n, exp_row);
      check("t5_prs", is_pressed, 1'b0);
      tick(1);
    end

    // 6: r3c3 held 100 clocks after acceptance
    keys[3*4+3] = 1'b1;
    wait_pressed(1'b1, 200, "t6_prs");
    check("t6_btn", button, 4'hD);
    for (int i = 1; i <= 100; i++) begin
      tick(1);
`ifdef KEYPAD_REPEAT_EN
      exp_p = !(i == 40 || i == 56 || i == 72 || i == 88);
`else
      exp_p = 1'b1;
`endif
      check("t6_prs", is_pressed, exp_p);
      check("t6_btn", button, 4'hD);
    end
    keys = 16'h0;
    wait_pressed(1'b0, 100, "t6_rel");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
